// File: rtl/pi_capture_pkg.sv
// Shared definitions for the Pi frame-capture scheduler: FSM encoding,
// frame geometry and the phases reserved for the video-output reader.
package pi_capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAP_ODD,
        CAP_EVEN,
        DRAIN
    } cap_state_t;

    localparam int LINE_DOTS   = 720;
    localparam int FIELD_LINES = 288;
    localparam int FRAME_LINES = 2 * FIELD_LINES;

    localparam logic [2:0] READ_SLOT_A = 3'd1;
    localparam logic [2:0] READ_SLOT_B = 3'd4;

    function automatic logic is_read_slot(input logic [2:0] phase);
        return (phase == READ_SLOT_A) || (phase == READ_SLOT_B);
    endfunction

endpackage

// File: rtl/pi_capture_fifo.sv
// Small synchronous FIFO buffering captured {address, pixel} pairs until the
// frame-store port has a free write slot. A full FIFO accepts a push when it pops.
module pi_capture_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_nReset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wData,
    output logic [WIDTH-1:0]       o_rData,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != (PTR_W + 1)'(DEPTH)) || w_pop);

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers above.
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wrPtr] <= i_wData;
    end

    assign o_rData = r_mem[r_rdPtr];
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/pi_capture_scheduler.sv
// Captures one interlaced Pi DPI frame (odd field then even field) into the
// single-port frame store, sharing the port with the video-output reader.
module pi_capture_scheduler #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 19,
    parameter int LINE_DOTS  = pi_capture_pkg::LINE_DOTS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              pixelClockX6,
    input  logic              nReset,
    input  logic [2:0]        pixelClockPhase,
    input  logic              vsync_pi,
    input  logic              displayEnabled_pi,
    input  logic              isFieldOdd_pi,
    input  logic [9:0]        frameLine_pi,
    input  logic [9:0]        fieldLineDot_pi,
    input  logic [DATA_W-1:0] pixelData_pi,
    input  logic              captureReq,
    input  logic              continuous,
    input  logic              clearOverflow,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdAck,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memWe,
    output logic              memRe,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              busy,
    output logic              captureDone,
    output logic              overflow
);

    import pi_capture_pkg::*;

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    cap_state_t        r_state;
    cap_state_t        w_nextState;
    logic              r_prevVSync;
    logic              r_rdValid;
    logic              r_overflow;

    logic              w_phase0;
    logic              w_fieldStart;
    logic              w_capturing;
    logic              w_coordLegal;
    logic              w_pushReq;
    logic              w_rdGrant;
    logic              w_wrGrant;
    logic              w_overflowSet;
    logic              w_captureDone;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic [CNT_W-1:0]  w_fifoCount;
    logic [ADDR_W-1:0] w_pixAddr;
    logic [ADDR_W-1:0] w_headAddr;
    logic [DATA_W-1:0] w_headData;
    logic [ENTRY_W-1:0] w_fifoHead;

    assign w_phase0     = (pixelClockPhase == 3'd0);
    assign w_fieldStart = w_phase0 && vsync_pi && !r_prevVSync;
    assign w_capturing  = (r_state == CAP_ODD) || (r_state == CAP_EVEN);
    assign w_coordLegal = (frameLine_pi < 10'(FRAME_LINES)) && (fieldLineDot_pi < 10'(LINE_DOTS));
    assign w_pixAddr    = ADDR_W'(frameLine_pi) * ADDR_W'(LINE_DOTS) + ADDR_W'(fieldLineDot_pi);
    assign w_pushReq    = w_capturing && w_phase0 && displayEnabled_pi && w_coordLegal;

    // Reads own their slot outright; writes take every other ready cycle.
    assign w_rdGrant     = nReset && memReady && rdReq && is_read_slot(pixelClockPhase);
    assign w_wrGrant     = nReset && memReady && !w_rdGrant && !w_fifoEmpty;
    assign w_overflowSet = w_pushReq && w_fifoFull && !w_wrGrant;

    pi_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (pixelClockX6),
        .i_nReset (nReset),
        .i_push   (w_pushReq),
        .i_pop    (w_wrGrant),
        .i_wData  ({w_pixAddr, pixelData_pi}),
        .o_rData  (w_fifoHead),
        .o_full   (w_fifoFull),
        .o_empty  (w_fifoEmpty),
        .o_count  (w_fifoCount)
    );

    assign {w_headAddr, w_headData} = w_fifoHead;

    always_comb begin
        w_nextState   = r_state;
        w_captureDone = 1'b0;
        unique case (r_state)
            IDLE:     if (captureReq) w_nextState = ARM;
            ARM:      if (w_fieldStart && isFieldOdd_pi) w_nextState = CAP_ODD;
            CAP_ODD:  if (w_fieldStart) w_nextState = CAP_EVEN;
            CAP_EVEN: if (w_fieldStart) w_nextState = DRAIN;
            DRAIN: begin
                if (w_fifoCount == '0) begin
                    w_captureDone = 1'b1;
                    w_nextState   = continuous ? ARM : IDLE;
                end
            end
            default:  w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge pixelClockX6 or negedge nReset) begin
        if (!nReset) begin
            r_state     <= IDLE;
            r_prevVSync <= 1'b1;
            r_rdValid   <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_rdValid <= w_rdGrant;
            if (w_phase0)
                r_prevVSync <= vsync_pi;
            if (w_overflowSet)
                r_overflow <= 1'b1;
            else if (clearOverflow)
                r_overflow <= 1'b0;
        end
    end

    assign memWe       = w_wrGrant;
    assign memRe       = w_rdGrant;
    assign rdAck       = w_rdGrant;
    assign memAddr     = w_rdGrant ? rdAddr : (w_wrGrant ? w_headAddr : '0);
    assign memWData    = w_wrGrant ? w_headData : '0;
    assign rdValid     = r_rdValid;
    assign rdData      = r_rdValid ? memRData : '0;
    assign busy        = (r_state != IDLE);
    assign captureDone = w_captureDone;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pi_capture_scheduler.sv
// Randomised bench for pi_capture_scheduler against a queue-based frame-capture model.
`timescale 1ns/1ps
module tb_pi_capture_scheduler;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 19;

    logic              pixelClockX6 = 1'b0;
    logic              nReset = 1'b0;
    logic [2:0]        pixelClockPhase = 3'd0;
    logic              vsync_pi = 1'b1;
    logic              displayEnabled_pi = 1'b0;
    logic              isFieldOdd_pi = 1'b0;
    logic [9:0]        frameLine_pi = '0;
    logic [9:0]        fieldLineDot_pi = '0;
    logic [DATA_W-1:0] pixelData_pi = '0;
    logic              captureReq = 1'b0;
    logic              continuous = 1'b0;
    logic              clearOverflow = 1'b0;
    logic              rdReq = 1'b0;
    logic [ADDR_W-1:0] rdAddr = '0;
    logic              rdAck;
    logic              rdValid;
    logic [DATA_W-1:0] rdData;
    logic [ADDR_W-1:0] memAddr;
    logic              memWe;
    logic              memRe;
    logic [DATA_W-1:0] memWData;
    logic [DATA_W-1:0] memRData = '0;
    logic              memReady = 1'b0;
    logic              busy;
    logic              captureDone;
    logic              overflow;

    pi_capture_scheduler dut (
        .pixelClockX6      (pixelClockX6),
        .nReset            (nReset),
        .pixelClockPhase   (pixelClockPhase),
        .vsync_pi          (vsync_pi),
        .displayEnabled_pi (displayEnabled_pi),
        .isFieldOdd_pi     (isFieldOdd_pi),
        .frameLine_pi      (frameLine_pi),
        .fieldLineDot_pi   (fieldLineDot_pi),
        .pixelData_pi      (pixelData_pi),
        .captureReq        (captureReq),
        .continuous        (continuous),
        .clearOverflow     (clearOverflow),
        .rdReq             (rdReq),
        .rdAddr            (rdAddr),
        .rdAck             (rdAck),
        .rdValid           (rdValid),
        .rdData            (rdData),
        .memAddr           (memAddr),
        .memWe             (memWe),
        .memRe             (memRe),
        .memWData          (memWData),
        .memRData          (memRData),
        .memReady          (memReady),
        .busy              (busy),
        .captureDone       (captureDone),
        .overflow          (overflow)
    );

    always #5 pixelClockX6 = ~pixelClockX6;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within 2 ms");
        $fatal(1, "timeout");
    end

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 waiting for an odd field, 2 odd field,
    // 3 even field, 4 flushing the buffer.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } entry_t;

    entry_t            q[$];
    int                mode;
    bit                mPrevVs, mOvf, mAckPrev;
    int                expPushes = 0, dutWrites = 0, dutDones = 0;
    logic [DATA_W-1:0] wmem [int];

    int  readyPct = 100, rdPct = 0, stall = 0;
    bit  rdDirected = 0, reqPulse = 0, clrPulse = 0;
    bit  g_vs = 1, g_de = 0, g_odd = 0;
    int  g_line = 0, g_dot = 0;
    logic [DATA_W-1:0] g_data = '0;

    task automatic model_reset();
        q.delete();
        mode = 0; mPrevVs = 1; mOvf = 0; mAckPrev = 0;
    endtask

    function automatic logic [63:0] dut_outs();
        return {6'd0, memWe, memRe, rdAck, rdValid, busy, captureDone, overflow, memAddr, memWData, rdData};
    endfunction

    task automatic tick(input int ph);
        bit fs, rdG, wrG, done, push, full;
        logic [ADDR_W-1:0] eAddr;
        logic [DATA_W-1:0] eWd, eRd;
        entry_t e;
        @(negedge pixelClockX6);
        pixelClockPhase = 3'(ph);
        if (ph == 0) begin
            vsync_pi = g_vs; displayEnabled_pi = g_de; isFieldOdd_pi = g_odd;
            frameLine_pi = 10'(g_line); fieldLineDot_pi = 10'(g_dot); pixelData_pi = g_data;
        end
        captureReq = reqPulse; reqPulse = 0;
        clearOverflow = clrPulse; clrPulse = 0;
        if (stall > 0) begin memReady = 0; stall--; end
        else memReady = ($urandom_range(99) < readyPct);
        if (mAckPrev) rdReq = 0;
        if (!rdReq && (rdDirected ? (ph == 2) : ($urandom_range(99) < rdPct))) begin
            rdReq = 1; rdAddr = ADDR_W'($urandom);
        end
        memRData = DATA_W'($urandom);
        #1;
        fs   = (ph == 0) && vsync_pi && !mPrevVs;
        rdG  = memReady && rdReq && (ph == 1 || ph == 4);
        wrG  = memReady && !rdG && (q.size() > 0);
        done = (mode == 4) && (q.size() == 0);
        eAddr = '0; eWd = '0;
        if (rdG) eAddr = rdAddr;
        else if (wrG) begin eAddr = q[0].a; eWd = q[0].d; end
        eRd = mAckPrev ? memRData : '0;
        check("outs", dut_outs(), {6'd0, wrG, rdG, rdG, mAckPrev, (mode != 0), done, mOvf, eAddr, eWd, eRd});
        if (rdDirected && rdAck) check("ack_phase", 64'(ph), 64'd4);
        if (memWe) begin wmem[int'(memAddr)] = memWData; dutWrites++; end
        if (captureDone) dutDones++;
        @(posedge pixelClockX6);
        if (wrG) void'(q.pop_front());
        push = (mode == 2 || mode == 3) && (ph == 0) && displayEnabled_pi && (frameLine_pi < 576) && (fieldLineDot_pi < 720);
        full = push && (q.size() >= 4);
        if (push && !full) begin
            e.a = ADDR_W'(int'(frameLine_pi) * 720 + int'(fieldLineDot_pi));
            e.d = pixelData_pi;
            q.push_back(e);
            expPushes++;
        end
        if (full) mOvf = 1;
        else if (clearOverflow) mOvf = 0;
        case (mode)
            0: if (captureReq) mode = 1;
            1: if (fs && isFieldOdd_pi) mode = 2;
            2: if (fs) mode = 3;
            3: if (fs) mode = 4;
            4: if (done) mode = continuous ? 1 : 0;
            default: mode = 0;
        endcase
        if (ph == 0) mPrevVs = vsync_pi;
        mAckPrev = rdG;
    endtask

    task automatic pixel(input bit vs, input bit de, input int line, input int dot, input logic [DATA_W-1:0] d);
        g_vs = vs; g_de = de; g_line = line; g_dot = dot; g_data = d;
        for (int ph = 0; ph < 6; ph++) tick(ph);
    endtask

    task automatic rand_pixels(input int n);
        int r, line, dot;
        for (int i = 0; i < n; i++) begin
            r    = $urandom_range(9);
            line = (r == 0) ? 576 + $urandom_range(447) : $urandom_range(575);
            dot  = (r == 1) ? 720 + $urandom_range(303) : $urandom_range(719);
            pixel(1, ($urandom_range(7) != 0), line, dot, DATA_W'($urandom));
        end
    endtask

    // Vertical blank, then the field start lands on the first active pixel.
    task automatic field(input bit odd, input int n);
        g_odd = odd;
        pixel(0, 0, 0, 0, '0);
        pixel(0, 0, 0, 0, '0);
        rand_pixels(n);
    endtask

    logic [DATA_W-1:0] dA, dB;
    int                wSnap, dSnap;

    initial begin
        model_reset();
        repeat (3) @(negedge pixelClockX6);
        #1 check("reset_outs", dut_outs(), 64'd0);
        nReset = 1'b1;

        // Even field while armed is ignored; capture starts on the odd field.
        readyPct = 100; rdPct = 0;
        reqPulse = 1;
        pixel(1, 0, 0, 0, '0);
        field(0, 10);
        check("arm_busy", 64'(busy), 64'd1);
        check("arm_writes", 64'(dutWrites), 64'd0);
        field(1, 12);
        dA = 16'hA5C3;
        pixel(1, 1, 1, 0, dA);
        field(0, 12);
        dB = 16'h3C5A;
        pixel(1, 1, 575, 719, dB);
        field(1, 2);
        check("frame_done", 64'(dutDones), 64'd1);
        check("frame_writes", 64'(dutWrites), 64'(expPushes));
        check("addr_720", 64'(wmem[720]), 64'(dA));
        check("addr_414719", 64'(wmem[414719]), 64'(dB));
        check("frame_ovf", 64'(overflow), 64'd0);
        check("frame_idle", 64'(busy), 64'd0);

        // Reads raised mid-pixel are served in the next read slot.
        reqPulse = 1;
        pixel(1, 0, 0, 0, '0);
        rdDirected = 1;
        field(1, 8);
        rdDirected = 0;
        pixel(1, 0, 0, 0, '0);

        // Sustained stall: five pushes against four entries.
        stall = 30;
        for (int i = 0; i < 6; i++) pixel(1, 1, 10, i, DATA_W'($urandom));
        check("ovf_set", 64'(overflow), 64'd1);
        rand_pixels(4);
        check("ovf_sticky", 64'(overflow), 64'd1);
        clrPulse = 1;
        pixel(1, 0, 0, 0, '0);
        check("ovf_clear", 64'(overflow), 64'd0);
        field(0, 6);
        field(1, 1);
        check("ovf_frame_done", 64'(dutDones), 64'd2);

        // Continuous mode re-arms on its own across two frames.
        readyPct = 70; rdPct = 30;
        continuous = 1;
        reqPulse = 1;
        pixel(1, 0, 0, 0, '0);
        dSnap = dutDones;
        field(1, 6); field(0, 6); field(1, 6); field(0, 6);
        field(1, 6); field(0, 6);
        continuous = 0;
        field(1, 6);
        rand_pixels(3);
        check("cont_dones", 64'(dutDones - dSnap), 64'd2);
        check("cont_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of the even field.
        readyPct = 100; rdPct = 0;
        reqPulse = 1;
        pixel(1, 0, 0, 0, '0);
        field(1, 4);
        field(0, 4);
        check("pre_reset_busy", 64'(busy), 64'd1);
        dSnap = dutDones;
        @(negedge pixelClockX6);
        pixelClockPhase = 3'd1; rdReq = 1; memReady = 1;
        #2 nReset = 1'b0;
        #1 check("reset_mid_outs", dut_outs(), 64'd0);
        model_reset();
        rdReq = 0; memReady = 0; pixelClockPhase = 3'd0;
        repeat (2) @(negedge pixelClockX6);
        #1 nReset = 1'b1;
        wSnap = dutWrites;
        rand_pixels(4);
        field(1, 4);
        field(0, 3);
        check("reset_idle", 64'(busy), 64'd0);
        check("reset_no_writes", 64'(dutWrites), 64'(wSnap));
        check("reset_no_done", 64'(dutDones), 64'(dSnap));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pi_capture_scheduler.md
Name: pi_capture_scheduler

Overview:
Sequences whole-frame capture of the Pi DPI pixel stream into the single-port frame store. It shares that memory port between the Pi-side capture writes and the video-output reader. Capture coordinates come from the Pi pixel tracker (frameLine, fieldLineDot, field parity). The block sits between the tracker and the frame-store memory controller.

Parameters:
DATA_W, 16, pixel data width
ADDR_W, 19, frame-store word address width (576*720 = 414720 < 2^19)
LINE_DOTS, 720, dots per line, used as the address multiplier
FIFO_DEPTH, 4, write-buffer entries (power of two)

Ports:
pixelClockX6  in  1  clock, 6x pixel rate
nReset  in  1  asynchronous, active-low reset
pixelClockPhase  in  3  pixel sub-phase, 0..5
vsync_pi  in  1  Pi vSync, active low
displayEnabled_pi  in  1  Pi visible-area flag
isFieldOdd_pi  in  1  field parity from the tracker
frameLine_pi  in  10  interleaved frame line, 0..575
fieldLineDot_pi  in  10  dot, 0..719
pixelData_pi  in  DATA_W  Pi pixel value
captureReq  in  1  one-cycle pulse, request a one-frame capture
continuous  in  1  re-arm automatically after each frame
clearOverflow  in  1  clears overflow
rdReq  in  1  read request, level, held until rdAck
rdAddr  in  ADDR_W  read address
rdAck  out  1  read accepted this cycle
rdValid  out  1  rdData valid (one cycle after rdAck)
rdData  out  DATA_W  read data
memAddr  out  ADDR_W  memory address
memWe  out  1  write strobe
memRe  out  1  read strobe
memWData  out  DATA_W  write data
memRData  in  DATA_W  read data, one-cycle latency
memReady  in  1  memory can accept an access this cycle
busy  out  1  state != IDLE
captureDone  out  1  one-cycle pulse at end of a frame capture
overflow  out  1  sticky: FIFO full when a pixel arrived

Behaviour:
- Reset: state=IDLE, FIFO empty, all outputs 0, prevVSync=1.
- Field start = rising edge of vsync_pi, sampled only on phase 0. Parity is read from isFieldOdd_pi in the same cycle.
- FSM:
  - IDLE: captureReq -> ARM. captureReq while not IDLE is ignored.
  - ARM: field start with odd parity -> CAP_ODD. Even-field starts are ignored.
  - CAP_ODD: next field start -> CAP_EVEN, regardless of parity.
  - CAP_EVEN: next field start -> DRAIN.
  - DRAIN: FIFO empty -> pulse captureDone for 1 cycle, then ARM if continuous else IDLE.
- Pixel capture: in CAP_ODD/CAP_EVEN, on phase 0 with displayEnabled_pi=1, push {addr, pixelData_pi} into the FIFO.
  - addr = frameLine_pi*LINE_DOTS + fieldLineDot_pi, computed at ADDR_W width with no truncation of a legal value.
  - Values frameLine_pi>575 or dot>719 are not pushed.
- FIFO full at push: pixel dropped and overflow set. overflow stays set until clearOverflow; a simultaneous set and clear leaves it set.
- Port arbitration, evaluated every clock, at most one access per cycle, only when memReady=1:
  - Phases 1 and 4 are read slots. If rdReq=1, issue memRe, memAddr=rdAddr, and pulse rdAck.
  - In all other cycles (including read slots with no rdReq), issue a write if the FIFO is non-empty: memWe, FIFO head popped the same cycle.
  - memReady=0: no strobe, nothing popped, rdReq keeps waiting.
- Read data: rdValid=1 and rdData=memRData exactly one cycle after rdAck.
- Push and pop in the same cycle are legal; count is unchanged and a full FIFO accepts the push.
- Worst case: 1 push per 6 cycles against >=4 write slots per 6 cycles, so overflow only occurs under sustained memReady=0.
- Reset mid-capture: FIFO contents discarded, no captureDone.

Decomposition:
- Shared package pi_capture_pkg holds:
  - state encoding (IDLE, ARM, CAP_ODD, CAP_EVEN, DRAIN);
  - LINE_DOTS=720, FIELD_LINES=288, FRAME_LINES=576;
  - READ_SLOT phases 1 and 4.
- One sub-module, pi_capture_fifo: synchronous FIFO with parameters DATA_W+ADDR_W and FIFO_DEPTH, exposing full, empty and count.

Test Plan:
1. Reset, captureReq, then one even field followed by odd field start -> state stays ARM through the even field, enters CAP_ODD at the odd start.
2. Full odd+even frame with memReady=1 -> exactly 414720 writes; line 1 dot 0 writes address 720; line 575 dot 719 writes address 414719; one captureDone; overflow=0.
3. rdReq held from phase 2 during capture -> rdAck at phase 4, rdValid next cycle with memRData value; no write in that cycle.
4. memReady=0 for 30 cycles during active pixels -> 5 pushes fill 4 entries, overflow=1, and it remains 1 after memReady returns until clearOverflow.
5. continuous=1 over two frames -> two captureDone pulses, re-arm without a new captureReq.
6. nReset asserted during CAP_EVEN -> all outputs 0 immediately, FIFO empty, state IDLE, no captureDone.
